// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module      : mem_ctrl_if
// Description : Bundle of the instruction-fetch port, the MEM-stage port and
//               the 8-bit external RAM bus served by mem_ctrl. The slave
//               modport is the controller's view; master is the surrounding
//               pipeline and RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_data;

    // MEM-stage port
    logic              mem_req;
    logic              mem_wr_en;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    // External byte-wide RAM bus
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_wr_en, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_wr_en, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output ram_dout, ram_a, ram_wr
    );
endinterface

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Single-port RAM arbiter/sequencer. Serialises 1/2/4-byte
//               IF and MEM accesses into byte beats on an 8-bit RAM bus and
//               assembles little-endian read data. MEM has priority over IF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    logic [2:0]        r_cnt;        // beat index within the transaction
    logic [2:0]        r_len;        // transaction length in bytes (1/2/4)
    logic [ADDR_W-1:0] r_ram_a;      // address of the current beat
    logic [DATA_W-1:0] r_wdata;      // store data, lowest byte is next beat
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_accept_mem;
    logic              w_accept_if;
    logic              w_flush_if;
    logic              w_last_rd;
    logic              w_more;
    logic [2:0]        w_cnt_inc;
    logic [1:0]        w_byte_idx;
    logic [2:0]        w_mem_len;

    logic              w_ram_wr;
    logic [7:0]        w_ram_dout;
    logic              w_if_done;
    logic              w_mem_done;

    // Request arbitration: MEM wins in IDLE, flushed fetches are never taken
    assign w_accept_mem = (r_state == ST_IDLE) && bus.mem_req;
    assign w_accept_if  = (r_state == ST_IDLE) && !bus.mem_req
                          && bus.if_req && !bus.if_flush;

    // A flush only cancels transactions that belong to the fetch side
    assign w_flush_if = bus.if_flush && (r_owner == OWN_IF)
                        && ((r_state == ST_READ) || (r_state == ST_DONE));

    // Reads need one extra cycle: byte k arrives the cycle after its address
    assign w_last_rd  = (r_cnt == r_len);
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_more     = (w_cnt_inc < r_len);
    assign w_byte_idx = 2'(r_cnt - 3'd1);

    assign w_mem_len = (bus.mem_size == 2'd0) ? 3'd1 :
                       (bus.mem_size == 2'd1) ? 3'd2 : 3'd4;

    // State register; rdy low freezes the sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and bus/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ram_wr    = 1'b0;
        w_ram_dout  = 8'h00;
        w_if_done   = 1'b0;
        w_mem_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_mem) begin
                    w_state_nxt = bus.mem_wr_en ? ST_WRITE : ST_READ;
                end else if (w_accept_if) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_flush_if) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_rd) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                // The stall gate keeps a frozen beat from being written twice
                w_ram_wr   = rdy;
                w_ram_dout = r_wdata[7:0];
                if (!w_more) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_if_done   = (r_owner == OWN_IF) && !bus.if_flush;
                w_mem_done  = (r_owner == OWN_MEM);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch the request, step addresses and assemble read bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_IF;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_ram_a     <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_mem) begin
                        r_owner <= OWN_MEM;
                        r_cnt   <= 3'd0;
                        r_len   <= w_mem_len;
                        r_ram_a <= bus.mem_addr;
                        r_wdata <= bus.mem_wdata;
                        if (!bus.mem_wr_en) begin
                            r_mem_rdata <= '0;
                        end
                    end else if (w_accept_if) begin
                        r_owner   <= OWN_IF;
                        r_cnt     <= 3'd0;
                        r_len     <= 3'd4;
                        r_ram_a   <= bus.if_addr;
                        r_if_data <= '0;
                    end
                end
                ST_READ: begin
                    if (!w_flush_if) begin
                        if (r_cnt != 3'd0) begin
                            if (r_owner == OWN_IF) begin
                                r_if_data[{w_byte_idx, 3'b000} +: 8] <= bus.ram_din;
                            end else begin
                                r_mem_rdata[{w_byte_idx, 3'b000} +: 8] <= bus.ram_din;
                            end
                        end
                        if (!w_last_rd) begin
                            r_cnt <= w_cnt_inc;
                        end
                        if (w_more) begin
                            r_ram_a <= r_ram_a + c_addr_step;
                        end
                    end
                end
                ST_WRITE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_more) begin
                        r_ram_a <= r_ram_a + c_addr_step;
                        r_wdata <= r_wdata >> 8;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ram_wr    = w_ram_wr;
    assign bus.ram_dout  = w_ram_dout;
    assign bus.ram_a     = r_ram_a;
    assign bus.if_done   = w_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.mem_done  = w_mem_done;
    assign bus.mem_rdata = r_mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl: directed scenarios plus
//               random IF/MEM accesses against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_mem [logic [31:0]];   // the external RAM
    logic [7:0] ref_mem [logic [31:0]];   // expected RAM contents

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram_mem[a] = b;
        ref_mem[a] = b;
    endtask

    // RAM: registered read, write on ram_wr; halts with rdy
    always @(posedge clk) begin
        if (rdy) begin
            if (bus.ram_wr) ram_mem[bus.ram_a] = bus.ram_dout;
            bus.ram_din <= ram_rd(bus.ram_a);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access issued from an IDLE cycle, with an optional stall
    // window (stall_len wall cycles of rdy low starting at wall cycle stall_at).
    task automatic run_access(input bit is_if, input bit wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int stall_at, input int stall_len, input string tag);
        int n;
        int exp_lat;
        int e;
        bit got;
        logic [31:0] exp_data;
        logic done;
        n        = is_if ? 4 : nbytes(size);
        exp_lat  = wr ? n : n + 1;
        exp_data = wr ? 32'h0 : ref_load(addr, n);
        if (wr) ref_store(addr, n, wdata);
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_wr_en = wr;
            bus.mem_size  = size;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end
        tick();
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        e   = 0;
        got = 1'b0;
        for (int t = 0; t < exp_lat + stall_len + 1 && !got; t++) begin
            rdy = !(t >= stall_at && t < stall_at + stall_len);
            #1;
            done = is_if ? bus.if_done : bus.mem_done;
            if (!rdy) begin
                chk({tag, "/stall_wr"}, 32'(bus.ram_wr), 32'h0);
                chk({tag, "/stall_done"}, 32'(done), 32'h0);
            end else begin
                if (e < n) begin
                    chk({tag, "/addr"}, bus.ram_a, addr + 32'(e));
                    chk({tag, "/wr"}, 32'(bus.ram_wr), 32'(wr));
                    if (wr) chk({tag, "/dout"}, 32'(bus.ram_dout), 32'(wdata[8*e +: 8]));
                end
                chk({tag, "/done"}, 32'(done), 32'(e == exp_lat));
                if (e == exp_lat) begin
                    got = 1'b1;
                    chk({tag, "/wall"}, 32'(t), 32'(exp_lat + stall_len));
                    if (!wr) chk({tag, "/data"}, is_if ? bus.if_data : bus.mem_rdata, exp_data);
                end
                e++;
            end
            if (!got) begin
                @(posedge clk);
                #0;
            end
        end
        rdy = 1'b1;
        chk({tag, "/completed"}, 32'(got), 32'h1);
        if (wr) begin
            for (int i = 0; i < n; i++)
                chk({tag, "/ram"}, 32'(ram_rd(addr + 32'(i))), 32'(ref_byte(addr + 32'(i))));
        end
        tick();
        chk({tag, "/done_pulse"}, 32'(is_if ? bus.if_done : bus.mem_done), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/ram_a"}, bus.ram_a, 32'h0);
        chk({tag, "/ram_wr"}, 32'(bus.ram_wr), 32'h0);
        chk({tag, "/ram_dout"}, 32'(bus.ram_dout), 32'h0);
        chk({tag, "/if_done"}, 32'(bus.if_done), 32'h0);
        chk({tag, "/mem_done"}, 32'(bus.mem_done), 32'h0);
        chk({tag, "/if_data"}, bus.if_data, 32'h0);
        chk({tag, "/mem_rdata"}, bus.mem_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          is_if;
        bit          wr;
        int          n;
        int          s_at;
        int          s_len;

        rst = 1'b1;
        rdy = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // Reset state
        tick();
        tick();
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Word fetch at 0x1000
        preload(32'h0000_1000, 8'h13);
        preload(32'h0000_1001, 8'h05);
        preload(32'h0000_1002, 8'h00);
        preload(32'h0000_1003, 8'h00);
        run_access(1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 0, 0, "fetch");
        chk("fetch/if_data", bus.if_data, 32'h0000_0513);

        // Simultaneous IF and MEM store: store first, fetch 7 cycles later
        ref_store(32'h0000_2000, 4, 32'hDEAD_BEEF);
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_1000;
        bus.mem_req   = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_size  = 2'd2;
        bus.mem_addr  = 32'h0000_2000;
        bus.mem_wdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_req = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            #1;
            if (t < 4) begin
                chk("prio/addr", bus.ram_a, 32'h0000_2000 + 32'(t));
                chk("prio/wr", 32'(bus.ram_wr), 32'h1);
            end
            chk("prio/if_done", 32'(bus.if_done), 32'h0);
            chk("prio/mem_done", 32'(bus.mem_done), 32'(t == 4));
            tick();
        end
        for (int c = 1; c <= 7; c++) begin
            #1;
            chk("prio/if_done_gap", 32'(bus.if_done), 32'(c == 7));
            if (c == 7) begin
                chk("prio/if_data", bus.if_data, 32'h0000_0513);
                bus.if_req = 1'b0;
            end
            tick();
        end
        chk("prio/ram0", 32'(ram_rd(32'h0000_2000)), 32'hEF);
        chk("prio/ram3", 32'(ram_rd(32'h0000_2003)), 32'hDE);

        // Byte load with bit 7 set: zero-extended
        preload(32'h0000_3001, 8'h80);
        run_access(1'b0, 1'b0, 2'd0, 32'h0000_3001, 32'h0, 0, 0, "ldb");
        chk("ldb/rdata", bus.mem_rdata, 32'h0000_0080);

        // Halfword load wrapping the address space
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0000_0000, 8'h12);
        run_access(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 0, 0, "ldh_wrap");
        chk("ldh_wrap/rdata", bus.mem_rdata, 32'h0000_1234);

        // Flush in cycle 2 of a fetch with a MEM load waiting
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1000;
        tick();                                   // accept; cycle 0
        tick();                                   // cycle 1
        bus.mem_req   = 1'b1;
        bus.mem_wr_en = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_addr  = 32'h0000_3001;
        tick();                                   // cycle 2
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        #1;
        chk("flush/if_done_c2", 32'(bus.if_done), 32'h0);
        chk("flush/wr_c2", 32'(bus.ram_wr), 32'h0);
        tick();                                   // cycle 3: idle
        bus.if_flush = 1'b0;
        #1;
        chk("flush/if_done_c3", 32'(bus.if_done), 32'h0);
        chk("flush/wr_c3", 32'(bus.ram_wr), 32'h0);
        tick();                                   // MEM cycle 0
        bus.mem_req = 1'b0;
        for (int c = 0; c <= 2; c++) begin
            #1;
            if (c == 0) chk("flush/mem_addr", bus.ram_a, 32'h0000_3001);
            chk("flush/if_done", 32'(bus.if_done), 32'h0);
            chk("flush/mem_done", 32'(bus.mem_done), 32'(c == 2));
            if (c == 2) chk("flush/rdata", bus.mem_rdata, 32'h0000_0080);
            tick();
        end

        // Halfword store stalled for 3 cycles after its first beat
        run_access(1'b0, 1'b1, 2'd1, 32'h0000_4000, 32'h0000_A55A, 1, 3, "stall_sh");

        // Reset in cycle 1 of a word store
        bus.mem_req   = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_size  = 2'd2;
        bus.mem_addr  = 32'h0000_5000;
        bus.mem_wdata = 32'h1122_3344;
        tick();                                   // accept; cycle 0
        bus.mem_req = 1'b0;
        tick();                                   // cycle 1
        rst = 1'b1;
        tick();                                   // cycle 2
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rst_mid/no_done", 32'(bus.mem_done), 32'h0);
            chk("rst_mid/no_wr", 32'(bus.ram_wr), 32'h0);
        end
        chk("rst_mid/ram2", 32'(ram_rd(32'h0000_5002)), 32'(init_byte(32'h0000_5002)));
        chk("rst_mid/ram3", 32'(ram_rd(32'h0000_5003)), 32'(init_byte(32'h0000_5003)));

        // Random traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            is_if = ($urandom_range(0, 3) == 0);
            wr    = is_if ? 1'b0 : 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           addr = 32'h0000_6000 + 32'($urandom_range(0, 63));
            wdata = $urandom();
            n     = is_if ? 4 : nbytes(size);
            if ($urandom_range(0, 3) == 0) begin
                s_len = $urandom_range(1, 3);
                s_at  = $urandom_range(0, n - 1);
            end else begin
                s_len = 0;
                s_at  = 0;
            end
            run_access(is_if, wr, size, addr, wdata, s_at, s_len,
                       is_if ? "rnd_if" : (wr ? "rnd_st" : "rnd_ld"));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
